dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single DataMemory port between two requesters: port 0 = processor load/store
//  path, port 1 = loader/debug master (memory preload, result dump). Per-cycle arbitration
//  with a bounded lock for bursts. Registered read-return pipeline routes ReadData back to
//  the requester that issued the read. Sits between the requesters and DataMemory.
// PARAMETERS
//  AW        64  address width (bits)
//  DW        64  data width (bits)
//  RD_LAT     1  read-return latency in CLK cycles, >=1 (register stages after DataMemory)
//  MAX_LOCK   8  max consecutive cycles a locked owner may hold the port, >=1
// PORTS
//  CLK                in   1    clock; all state updates on posedge
//  Reset_L            in   1    asynchronous, active-low reset
//  req0/req1          in   1    requester n wants the port this cycle
//  wr0/wr1            in   1    1 = write, 0 = read
//  lock0/lock1        in   1    keep ownership after this access (burst)
//  addr0/addr1        in   AW   access address
//  wdata0/wdata1      in   DW   write data
//  gnt0/gnt1          out  1    access accepted this cycle (combinational from req/state)
//  rvalid0/rvalid1    out  1    read data valid for requester n
//  rdata0/rdata1      out  DW   read data
//  MemoryRead         out  1    to DataMemory
//  MemoryWrite        out  1    to DataMemory
//  Address            out  AW   to DataMemory
//  WriteData          out  DW   to DataMemory
//  ReadData           in   DW   from DataMemory (combinational read)
// BEHAVIOUR
//  - Reset (Reset_L=0, async): state=IDLE, rr_last=1 (port 0 wins first tie), lock_cnt=0,
//    return pipeline cleared; gnt*, rvalid*, MemoryRead, MemoryWrite = 0; rdata* = 0.
//  - FSM: IDLE, OWN0, OWN1. OWNn: only requester n may be granted.
//  - IDLE: one req -> grant it. Both -> grant port != rr_last. Grant in same cycle as req.
//  - Granted access with lockn=1 -> next state OWNn, lock_cnt=1; else stay IDLE.
//  - OWNn: reqn&lockn -> grant, lock_cnt++; lock_cnt reaching MAX_LOCK -> IDLE (forced release).
//    reqn & !lockn -> grant, last access of burst, -> IDLE. !reqn -> IDLE, no grant that cycle.
//  - rr_last <= granted port on every grant (locked grants included).
//  - Memory side: MemoryRead = gnt & !wr, MemoryWrite = gnt & wr, Address/WriteData muxed
//    from granted port; when nothing granted Address/WriteData = 0, strobes 0.
//  - Return pipe: at posedge with a read grant, capture {valid, id, ReadData} into stage 1;
//    shifts one stage per cycle; stage RD_LAT drives rvalid_id=1 and rdata_id (other port's
//    rvalid=0, rdata holds last value). Read issued cycle t -> rvalid at t+RD_LAT. One read
//    per cycle sustained; no backpressure on return.
//  - Writes produce no rvalid. Write then read same address in consecutive cycles returns
//    the new data (DataMemory writes on edge).
//  - Reset mid-burst / mid-read: lock dropped, in-flight returns discarded (no rvalid).
//  - req with no grant: requester holds req/addr/wdata stable until gnt.
// CONFIGURATION
//  DMEM_ARB_FIXED_PRIO_EN defined: IDLE tie-break always port 0; lock still honoured.
//  Undefined: round-robin tie-break via rr_last as above.
// STRUCTURE
//  Shared package dmem_arb_pkg: state encoding localparams (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2),
//  port-id constants. One sub-module: dmem_rd_return_pipe (RD_LAT-deep valid/id/data shifter).
// TESTING
//  1 req0 read @0x10 only (mem[0x10]=0xAA) -> gnt0 same cycle, rvalid0=1 rdata0=0xAA after RD_LAT.
//  2 req0&req1 held 4 cycles, no lock -> grants 0,1,0,1 (with FIXED_PRIO_EN: 0,0,0,0).
//  3 req1 lock1=1 for 12 cycles, req0 held, MAX_LOCK=8 -> gnt1 8 cycles, then gnt0 next cycle.
//  4 write port1 0x20<=0x55 then port0 read 0x20 next cycle -> rdata0=0x55, rvalid1 never set.
//  5 alternating reads 0/1 back-to-back, RD_LAT=3 -> rvalid/rdata return to correct port in order.
//  6 Reset_L low while OWN1 with read in flight -> outputs 0 immediately, no rvalid after release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the DataMemory port arbiter: FSM state encoding and requester ids.
package dmem_arb_pkg;

   localparam logic [1:0] IDLE_ENC = 2'd0;
   localparam logic [1:0] OWN0_ENC = 2'd1;
   localparam logic [1:0] OWN1_ENC = 2'd2;

   typedef enum logic [1:0] {
      IDLE = IDLE_ENC,
      OWN0 = OWN0_ENC,
      OWN1 = OWN1_ENC
   } arb_state_t;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_rd_return_pipe.sv
// RD_LAT-deep shifter carrying {valid, id, data} of each read back to its requester;
// the last stage is split per port so each rdata holds its most recent return.
module dmem_rd_return_pipe
   import dmem_arb_pkg::*;
#(
   parameter int DW     = 64,
   parameter int RD_LAT = 1
) (
   input  logic          CLK,
   input  logic          Reset_L,
   input  logic          cap_valid,
   input  logic          cap_id,
   input  logic [DW-1:0] cap_data,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1
);

   logic          fin_valid;
   logic          fin_id;
   logic [DW-1:0] fin_data;

   generate
      if (RD_LAT == 1) begin : g_direct
         assign fin_valid = cap_valid;
         assign fin_id    = cap_id;
         assign fin_data  = cap_data;
      end else begin : g_shift
         logic [RD_LAT-2:0] v_q;
         logic [RD_LAT-2:0] id_q;
         logic [DW-1:0]     d_q [RD_LAT-1];

         // NOTE: the data stages are reset as well so that nothing stale can reach rdata after a reset.
         always_ff @(posedge CLK or negedge Reset_L) begin
            if (!Reset_L) begin
               v_q  <= '0;
               id_q <= '0;
               for (int i = 0; i < RD_LAT - 1; i++) d_q[i] <= '0;
            end else begin
               v_q[0]  <= cap_valid;
               id_q[0] <= cap_id;
               d_q[0]  <= cap_data;
               for (int i = 1; i < RD_LAT - 1; i++) begin
                  v_q[i]  <= v_q[i-1];
                  id_q[i] <= id_q[i-1];
                  d_q[i]  <= d_q[i-1];
               end
            end
         end

         assign fin_valid = v_q[RD_LAT-2];
         assign fin_id    = id_q[RD_LAT-2];
         assign fin_data  = d_q[RD_LAT-2];
      end
   endgenerate

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= fin_valid & (fin_id == PORT0);
         rvalid1 <= fin_valid & (fin_id == PORT1);
         if (fin_valid && fin_id == PORT0) rdata0 <= fin_data;
         if (fin_valid && fin_id == PORT1) rdata1 <= fin_data;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single DataMemory port with bounded burst lock and read return.
// Build option: DMEM_ARB_FIXED_PRIO_EN makes port 0 win every idle tie instead of round-robin.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW       = 64,
   parameter int DW       = 64,
   parameter int RD_LAT   = 1,
   parameter int MAX_LOCK = 8
) (
   input  logic          CLK,
   input  logic          Reset_L,
   input  logic          req0,
   input  logic          req1,
   input  logic          wr0,
   input  logic          wr1,
   input  logic          lock0,
   input  logic          lock1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          MemoryRead,
   output logic          MemoryWrite,
   output logic [AW-1:0] Address,
   output logic [DW-1:0] WriteData,
   input  logic [DW-1:0] ReadData
);

   localparam int            CW      = $clog2(MAX_LOCK + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

   arb_state_t    state, next_state;
   logic [CW-1:0] lock_cnt, next_cnt;
   logic          rr_last;
   logic          tie_to0;
   logic          gnt0_raw, gnt1_raw;

   // NOTE: every signal is given a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      next_state = state;
      next_cnt   = lock_cnt;
      gnt0_raw   = 1'b0;
      gnt1_raw   = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      tie_to0    = 1'b1;
`else
      tie_to0    = (rr_last == PORT1);
`endif
      unique case (state)
         IDLE: begin
            gnt0_raw = req0 & (~req1 | tie_to0);
            gnt1_raw = req1 & ~gnt0_raw;
            next_cnt = '0;
            // A one-cycle lock limit means the opening access already exhausts the burst.
            if (((gnt0_raw & lock0) | (gnt1_raw & lock1)) && (CNT_MAX > CW'(1))) begin
               next_state = gnt0_raw ? OWN0 : OWN1;
               next_cnt   = CW'(1);
            end
         end
         OWN0: begin
            gnt0_raw = req0;
            if (req0 && lock0 && (lock_cnt + CW'(1) < CNT_MAX)) begin
               next_cnt = lock_cnt + CW'(1);
            end else begin
               next_state = IDLE;
               next_cnt   = '0;
            end
         end
         OWN1: begin
            gnt1_raw = req1;
            if (req1 && lock1 && (lock_cnt + CW'(1) < CNT_MAX)) begin
               next_cnt = lock_cnt + CW'(1);
            end else begin
               next_state = IDLE;
               next_cnt   = '0;
            end
         end
         default: begin
            next_state = IDLE;
            next_cnt   = '0;
         end
      endcase
   end

   // Grants are combinational from req, so they are masked while reset is held.
   assign gnt0 = gnt0_raw & Reset_L;
   assign gnt1 = gnt1_raw & Reset_L;

   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state    <= IDLE;
         lock_cnt <= '0;
         rr_last  <= PORT1;
      end else begin
         state    <= next_state;
         lock_cnt <= next_cnt;
         if (gnt0 | gnt1) rr_last <= gnt1 ? PORT1 : PORT0;
      end
   end

   assign MemoryRead  = (gnt0 & ~wr0) | (gnt1 & ~wr1);
   assign MemoryWrite = (gnt0 & wr0) | (gnt1 & wr1);
   assign Address     = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
   assign WriteData   = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

   dmem_rd_return_pipe #(
      .DW     (DW),
      .RD_LAT (RD_LAT)
   ) u_rd_return_pipe (
      .CLK       (CLK),
      .Reset_L   (Reset_L),
      .cap_valid (MemoryRead),
      .cap_id    (gnt1),
      .cap_data  (ReadData),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .rdata0    (rdata0),
      .rdata1    (rdata1)
   );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus random traffic against a
// burst/ownership-level reference model with a return queue and shadow memory.
module tb_dmem_port_arbiter;

   localparam int AW       = 64;
   localparam int DW       = 64;
   localparam int RD_LAT   = 3;
   localparam int MAX_LOCK = 8;
`ifdef DMEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          Reset_L;
   logic          req0, req1, wr0, wr1, lock0, lock1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic          MemoryRead, MemoryWrite;
   logic [AW-1:0] Address;
   logic [DW-1:0] WriteData;
   logic [DW-1:0] ReadData;

   dmem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)) dut (
      .CLK(CLK), .Reset_L(Reset_L),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1), .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite),
      .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
   );

   always #5 CLK = ~CLK;

   // DataMemory stand-in: combinational read, write on the clock edge.
   logic [DW-1:0] mem [256];
   assign ReadData = mem[Address[7:0]];
   always @(posedge CLK) if (MemoryWrite) mem[Address[7:0]] <= WriteData;

   typedef struct {
      int            due;
      int            port;
      logic [DW-1:0] data;
   } ret_t;

   int            vectors     = 0;
   int            miscompares = 0;
   int            owner, burst, last_win, cyc, win;
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] exp_rdata [2];
   ret_t          rq [$];
   logic          obs_g0, obs_g1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      owner    = -1;
      burst    = 0;
      last_win = 1;
      cyc      = 0;
      rq.delete();
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
   endtask

   task automatic set_in(input int p, input bit rq_i, input bit w, input bit lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p == 0) begin
         req0 = rq_i; wr0 = w; lock0 = lk; addr0 = a; wdata0 = d;
      end else begin
         req1 = rq_i; wr1 = w; lock1 = lk; addr1 = a; wdata1 = d;
      end
   endtask

   // One clock: predict and compare mid-cycle, then advance the model at the edge.
   task automatic cycle();
      int            w;
      bit            is_rd, is_wr, is_lk;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      bit            rv0, rv1;
      ret_t          e;
      @(negedge CLK);
      w = -1;
      if (owner >= 0) begin
         if ((owner == 0) ? req0 : req1) w = owner;
      end else if (req0 && req1) w = FIXED ? 0 : 1 - last_win;
      else if (req0) w = 0;
      else if (req1) w = 1;
      win   = w;
      a     = (w == 0) ? addr0 : ((w == 1) ? addr1 : '0);
      d     = (w == 0) ? wdata0 : ((w == 1) ? wdata1 : '0);
      is_wr = (w == 0) ? wr0 : ((w == 1) ? wr1 : 1'b0);
      is_lk = (w == 0) ? lock0 : ((w == 1) ? lock1 : 1'b0);
      is_rd = (w >= 0) && !is_wr;
      obs_g0 = gnt0;
      obs_g1 = gnt1;
      check("gnt0", gnt0, w == 0);
      check("gnt1", gnt1, w == 1);
      check("MemoryRead", MemoryRead, is_rd);
      check("MemoryWrite", MemoryWrite, is_wr);
      check("Address", Address, a);
      check("WriteData", WriteData, d);
      rv0 = 1'b0;
      rv1 = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         e = rq.pop_front();
         exp_rdata[e.port] = e.data;
         rv0 = (e.port == 0);
         rv1 = (e.port == 1);
      end
      check("rvalid0", rvalid0, rv0);
      check("rvalid1", rvalid1, rv1);
      check("rdata0", rdata0, exp_rdata[0]);
      check("rdata1", rdata1, exp_rdata[1]);
      @(posedge CLK);
      if (w >= 0) begin
         if (is_rd) begin
            e.due  = cyc + RD_LAT;
            e.port = w;
            e.data = ref_mem[a[7:0]];
            rq.push_back(e);
         end
         if (is_wr) ref_mem[a[7:0]] = d;
         if (is_lk) begin
            burst = (owner == w) ? burst + 1 : 1;
            owner = (burst >= MAX_LOCK) ? -1 : w;
            if (owner < 0) burst = 0;
         end else begin
            owner = -1;
            burst = 0;
         end
         last_win = w;
      end else begin
         owner = -1;
         burst = 0;
      end
      cyc++;
      #1;
   endtask

   task automatic idle_cycles(input int n);
      set_in(0, 0, 0, 0, '0, '0);
      set_in(1, 0, 0, 0, '0, '0);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int n1;
      bit g0_after;
      Reset_L = 1'b0;
      set_in(0, 1, 0, 0, 64'h10, '0);
      set_in(1, 1, 1, 0, 64'h20, 64'h1);
      reset_model();
      #12;
      // Reset state, with both requests asserted
      check("rst_gnt0", gnt0, 1'b0);
      check("rst_gnt1", gnt1, 1'b0);
      check("rst_mrd", MemoryRead, 1'b0);
      check("rst_mwr", MemoryWrite, 1'b0);
      check("rst_rvalid0", rvalid0, 1'b0);
      check("rst_rvalid1", rvalid1, 1'b0);
      check("rst_rdata0", rdata0, '0);
      check("rst_rdata1", rdata1, '0);
      set_in(0, 0, 0, 0, '0, '0);
      set_in(1, 0, 0, 0, '0, '0);
      @(posedge CLK);
      #2 Reset_L = 1'b1;

      // Preload every word through the loader port
      for (int i = 0; i < 256; i++) begin
         set_in(1, 1, 1, 0, 64'(i), (i == 16) ? 64'hAA : {32'(i) ^ 32'h5A5A_0000, $urandom});
         cycle();
      end
      idle_cycles(2);

      // 1: single processor read
      set_in(0, 1, 0, 0, 64'h10, '0);
      cycle();
      idle_cycles(RD_LAT);
      check("t1_rdata0", rdata0, 64'hAA);

      // 2: both requesters, no lock
      set_in(0, 1, 0, 0, 64'h11, '0);
      set_in(1, 1, 0, 0, 64'h12, '0);
      for (int i = 0; i < 4; i++) cycle();
      idle_cycles(RD_LAT);

      // 3: port 1 locked burst against a waiting port 0
      set_in(1, 1, 0, 1, 64'h40, '0);
      n1 = 0;
      g0_after = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (i == 0) set_in(0, 1, 0, 0, 64'h50, '0);
         if (i < 8 && obs_g1) n1++;
         if (i == 8) g0_after = obs_g0;
      end
      check("t3_burst_len", 64'(n1), 64'd8);
      check("t3_release_gnt0", g0_after, 1'b1);
      idle_cycles(RD_LAT + 1);

      // 4: loader write then processor read of the same word
      set_in(1, 1, 1, 0, 64'h20, 64'h55);
      cycle();
      set_in(1, 0, 0, 0, '0, '0);
      set_in(0, 1, 0, 0, 64'h20, '0);
      cycle();
      idle_cycles(RD_LAT);
      check("t4_rdata0", rdata0, 64'h55);

      // 5: alternating back-to-back reads
      for (int i = 0; i < 8; i++) begin
         set_in(i % 2, 1, 0, 0, 64'(32 + i), '0);
         set_in(1 - (i % 2), 0, 0, 0, '0, '0);
         cycle();
      end
      idle_cycles(RD_LAT);

      // Random traffic, each request held until granted
      set_in(0, 0, 0, 0, '0, '0);
      set_in(1, 0, 0, 0, '0, '0);
      win = -1;
      for (int i = 0; i < 400; i++) begin
         if (!req0 || win == 0)
            set_in(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                   64'($urandom_range(0, 255)), {$urandom, $urandom});
         if (!req1 || win == 1)
            set_in(1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                   64'($urandom_range(0, 255)), {$urandom, $urandom});
         cycle();
      end
      idle_cycles(RD_LAT + 2);

      // 6: reset while port 1 owns the port with reads in flight
      set_in(1, 1, 0, 1, 64'h30, '0);
      cycle();
      cycle();
      Reset_L = 1'b0;
      #1;
      check("t6_gnt1", gnt1, 1'b0);
      check("t6_mrd", MemoryRead, 1'b0);
      check("t6_rvalid0", rvalid0, 1'b0);
      check("t6_rvalid1", rvalid1, 1'b0);
      check("t6_rdata0", rdata0, '0);
      check("t6_rdata1", rdata1, '0);
      set_in(1, 0, 0, 0, '0, '0);
      reset_model();
      #2 Reset_L = 1'b1;
      idle_cycles(RD_LAT + 2);
      set_in(0, 1, 0, 0, 64'h33, '0);
      set_in(1, 1, 0, 0, 64'h34, '0);
      cycle();
      idle_cycles(RD_LAT + 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
